selector_micro: RTL and testbench

SELECTOR_MICRO -- requirements
Module: selector_micro

---
 rtl/selector_micro_pkg.sv | 15 +
 rtl/selector_micro_mux.sv | 32 +++
 rtl/selector_micro.sv | 48 ++++
 tb/tb_selector_micro.sv | 131 +++++++++++++
 4 files changed

// File: rtl/selector_micro_pkg.sv
// Shared write-data select codes and default datapath width for the
// micro control unit and the write-data selector.
package selector_micro_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        SEL_R0   = 3'd0,
        SEL_DATO = 3'd1,
        SEL_NUM  = 3'd2,
        SEL_PC   = 3'd3,
        SEL_RY   = 3'd4
    } sel_dw_e;

endpackage

// File: rtl/selector_micro_mux.sv
// Combinational 5:1 write-data mux; undefined codes give zero and raise invalid.
module selector_micro_mux
    import selector_micro_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] dato,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] ry,
    output logic [WIDTH-1:0] dw,
    output logic             invalid
);

    // Explicit per-code arms keep unknowns on unselected inputs out of dw.
    always_comb begin
        dw      = '0;
        invalid = 1'b0;
        case (sel)
            SEL_W'(SEL_R0):   dw = r0;
            SEL_W'(SEL_DATO): dw = dato;
            SEL_W'(SEL_NUM):  dw = num;
            SEL_W'(SEL_PC):   dw = pc;
            SEL_W'(SEL_RY):   dw = ry;
            default:          invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/selector_micro.sv
// Write-data selector: registers the muxed source and an invalid-code flag
// with one cycle of latency and a synchronous active-high reset.
module selector_micro
    import selector_micro_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SEL_W-1:0] Sel_DW,
    input  logic [WIDTH-1:0] R0,
    input  logic [WIDTH-1:0] i_dato,
    input  logic [WIDTH-1:0] Num,
    input  logic [WIDTH-1:0] o_direccion_instruccion,
    input  logic [WIDTH-1:0] Ry,
    output logic [WIDTH-1:0] DW,
    output logic             o_sel_invalido
);

    logic [WIDTH-1:0] mux_dw;
    logic             mux_invalid;

    selector_micro_mux #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .sel     (Sel_DW),
        .r0      (R0),
        .dato    (i_dato),
        .num     (Num),
        .pc      (o_direccion_instruccion),
        .ry      (Ry),
        .dw      (mux_dw),
        .invalid (mux_invalid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            DW             <= '0;
            o_sel_invalido <= 1'b0;
        end else begin
            DW             <= mux_dw;
            o_sel_invalido <= mux_invalid;
        end
    end

endmodule

// File: tb/tb_selector_micro.sv
// Directed-vector bench for selector_micro with hand-computed expectations.
module tb_selector_micro;

    logic       i_clk;
    logic       i_rst;
    logic [2:0] Sel_DW;
    logic [7:0] R0, i_dato, Num, o_direccion_instruccion, Ry;
    logic [7:0] DW;
    logic       o_sel_invalido;

    int total = 0;
    int bad   = 0;

    selector_micro #(.WIDTH(8), .SEL_W(3)) dut (
        .i_clk                   (i_clk),
        .i_rst                   (i_rst),
        .Sel_DW                  (Sel_DW),
        .R0                      (R0),
        .i_dato                  (i_dato),
        .Num                     (Num),
        .o_direccion_instruccion (o_direccion_instruccion),
        .Ry                      (Ry),
        .DW                      (DW),
        .o_sel_invalido          (o_sel_invalido)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        R0 = v; i_dato = v; Num = v; o_direccion_instruccion = v; Ry = v;
    endtask

    initial begin
        i_rst = 1'b1;
        Sel_DW = 3'd1;
        set_all(8'h00);
        i_dato = 8'hFF;
        step();
        chk("rst_dw", DW, 8'h00);
        chk("rst_inv", o_sel_invalido, 1'b0);

        // First non-reset edge loads the selected source.
        i_rst = 1'b0;
        step();
        chk("post_rst_dw", DW, 8'hFF);

        R0 = 8'd0; i_dato = 8'd1; Num = 8'd2; o_direccion_instruccion = 8'd3; Ry = 8'd4;
        for (int s = 0; s < 5; s++) begin
            Sel_DW = 3'(s);
            step();
            chk($sformatf("sweep_dw%0d", s), DW, 32'(s));
            chk($sformatf("sweep_inv%0d", s), o_sel_invalido, 1'b0);
        end

        set_all(8'hAA);
        for (int s = 5; s < 8; s++) begin
            Sel_DW = 3'(s);
            step();
            chk($sformatf("inval_dw%0d", s), DW, 8'h00);
            chk($sformatf("inval_flag%0d", s), o_sel_invalido, 1'b1);
        end
        Sel_DW = 3'd2;
        Num = 8'h5A;
        step();
        chk("recover_dw", DW, 8'h5A);
        chk("recover_inv", o_sel_invalido, 1'b0);

        // Mid-cycle input change must wait for the next edge.
        Sel_DW = 3'd4;
        Ry = 8'h11;
        step();
        chk("lat_first", DW, 8'h11);
        #2 Ry = 8'h22;
        #1 chk("lat_hold", DW, 8'h11);
        step();
        chk("lat_new", DW, 8'h22);

        // Simultaneous select and data change picks the new data of the new source.
        Sel_DW = 3'd1;
        i_dato = 8'hC3;
        step();
        chk("simul_dw", DW, 8'hC3);

        Sel_DW = 3'd3;
        o_direccion_instruccion = 8'h80;
        step();
        chk("mid_pre", DW, 8'h80);
        i_rst = 1'b1;
        step();
        chk("mid_rst_dw", DW, 8'h00);
        chk("mid_rst_inv", o_sel_invalido, 1'b0);
        i_rst = 1'b0;
        step();
        chk("mid_post", DW, 8'h80);

        // Reset must also clear a raised invalid flag.
        Sel_DW = 3'd6;
        step();
        chk("inv_before_rst", o_sel_invalido, 1'b1);
        i_rst = 1'b1;
        step();
        chk("inv_after_rst", o_sel_invalido, 1'b0);
        i_rst = 1'b0;

        Sel_DW = 3'd0;
        R0 = 8'h3C;
        i_dato = 'x; Num = 'x; o_direccion_instruccion = 'x; Ry = 'x;
        step();
        chk("iso_dw", DW, 8'h3C);
        chk("iso_inv", o_sel_invalido, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
